// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, RV32I major opcodes and immediate format codes
// used by the issue stage and the execute ALU.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      IMM_I     = 2'd0,
      IMM_S     = 2'd1,
      IMM_U     = 2'd2,
      IMM_SHAMT = 2'd3
   } imm_fmt_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction handshake plus the registered ALU-side outputs of the issue stage.
interface alu_issue_stage_if #(parameter int XLEN = 32);

   logic            flush_in;
   logic            in_valid_in;
   logic            in_ready_o;
   logic [31:0]     instr_in;
   logic [XLEN-1:0] pc_in;
   logic [XLEN-1:0] rs1_data_in;
   logic [XLEN-1:0] rs2_data_in;
   logic            out_valid_o;
   logic            out_ready_in;
   logic [XLEN-1:0] op_1_o;
   logic [XLEN-1:0] op_2_o;
   logic [3:0]      opcode_o;
   logic [4:0]      rd_o;
   logic            wb_en_o;
   logic [XLEN-1:0] store_data_o;
   logic            illegal_o;
   logic [XLEN-1:0] pc_o;

   modport master (
      output flush_in, in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
      input  in_ready_o, out_valid_o, op_1_o, op_2_o, opcode_o, rd_o, wb_en_o,
             store_data_o, illegal_o, pc_o
   );

   modport slave (
      input  flush_in, in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
      output in_ready_o, out_valid_o, op_1_o, op_2_o, opcode_o, rd_o, wb_en_o,
             store_data_o, illegal_o, pc_o
   );

endinterface

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate generator; every immediate except the shift
// amount is sign-extended from instruction bit 31.
module alu_imm_gen
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:7]     instr,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:     imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
         IMM_S:     imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
         IMM_U:     imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
         IMM_SHAMT: imm = {{(XLEN-5){1'b0}}, instr[24:20]};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the execute ALU: decodes one RV32I instruction
// per handshake and holds operands, opcode and writeback info in an output register.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
   input logic               clk_in,
   input logic               rst_n_in,
   alu_issue_stage_if.slave  bus
);

   logic [6:0]      major;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic            is_shift;
   imm_fmt_e        imm_fmt;
   logic [XLEN-1:0] imm;

   logic            legal;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] src_1;
   logic [XLEN-1:0] src_2;

   logic            load;
   logic            valid_reg;
   logic [XLEN-1:0] op_1_reg;
   logic [XLEN-1:0] op_2_reg;
   logic [3:0]      opcode_reg;
   logic [4:0]      rd_reg;
   logic            wb_en_reg;
   logic [XLEN-1:0] store_data_reg;
   logic            illegal_reg;
   logic [XLEN-1:0] pc_reg;

   assign major    = bus.instr_in[6:0];
   assign funct3   = bus.instr_in[14:12];
   assign funct7   = bus.instr_in[31:25];
   assign rd       = bus.instr_in[11:7];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      imm_fmt = IMM_I;
      case (major)
         OPC_OP_IMM:         imm_fmt = is_shift ? IMM_SHAMT : IMM_I;
         OPC_STORE:          imm_fmt = IMM_S;
         OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
         default:            imm_fmt = IMM_I;
      endcase
   end

   alu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (bus.instr_in[31:7]),
      .fmt   (imm_fmt),
      .imm   (imm)
   );

   always_comb begin
      legal  = 1'b1;
      alu_op = ALU_ADD;
      src_1  = '0;
      src_2  = '0;
      case (major)
         OPC_OP: begin
            legal  = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            alu_op = {bus.instr_in[30], funct3};
            src_1  = bus.rs1_data_in;
            src_2  = is_shift ? {{(XLEN-5){1'b0}}, bus.rs2_data_in[4:0]} : bus.rs2_data_in;
         end
         OPC_OP_IMM: begin
            // Only SRAI borrows instr[30]; ADDI with a negative immediate must stay ADD.
            if (funct3 == 3'b001)
               legal = (funct7 == F7_ZERO);
            else if (funct3 == 3'b101)
               legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            alu_op = {(funct3 == 3'b101) && bus.instr_in[30], funct3};
            src_1  = bus.rs1_data_in;
            src_2  = imm;
         end
         OPC_LUI: src_2 = imm;
         OPC_AUIPC: begin
            src_1 = bus.pc_in;
            src_2 = imm;
         end
         OPC_LOAD, OPC_STORE: begin
            src_1 = bus.rs1_data_in;
            src_2 = imm;
         end
         OPC_JAL, OPC_JALR: begin
            src_1 = bus.pc_in;
            src_2 = XLEN'(4);
         end
         default: legal = 1'b0;
      endcase
   end

   assign bus.in_ready_o = !bus.flush_in && (!valid_reg || bus.out_ready_in);
   assign load           = bus.in_valid_in && bus.in_ready_o;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         valid_reg      <= 1'b0;
         op_1_reg       <= '0;
         op_2_reg       <= '0;
         opcode_reg     <= ALU_ADD;
         rd_reg         <= '0;
         wb_en_reg      <= 1'b0;
         store_data_reg <= '0;
         illegal_reg    <= 1'b0;
         pc_reg         <= RESET_PC_OUT;
      end else if (bus.flush_in) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg      <= 1'b1;
         op_1_reg       <= legal ? src_1 : '0;
         op_2_reg       <= legal ? src_2 : '0;
         opcode_reg     <= legal ? alu_op : ALU_ADD;
         rd_reg         <= rd;
         wb_en_reg      <= legal && (major != OPC_STORE) && (rd != 5'd0);
         store_data_reg <= (major == OPC_STORE) ? bus.rs2_data_in : '0;
         illegal_reg    <= !legal;
         pc_reg         <= bus.pc_in;
      end else if (bus.out_ready_in) begin
         valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid_o  = valid_reg;
   assign bus.op_1_o       = op_1_reg;
   assign bus.op_2_o       = op_2_reg;
   assign bus.opcode_o     = opcode_reg;
   assign bus.rd_o         = rd_reg;
   assign bus.wb_en_o      = wb_en_reg;
   assign bus.store_data_o = store_data_reg;
   assign bus.illegal_o    = illegal_reg;
   assign bus.pc_o         = pc_reg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage directly upstream of the 32-bit execute ALU.
- Accepts one RV32I instruction per handshake, together with its PC and register-file read data.
- Decodes the instruction into the ALU's 4-bit opcode and selects the two operands.
- Holds the result in an output pipeline register under a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediates
- RESET_PC_OUT, 0, value of pc_o after reset

Ports:
- clk_in  input  1  clock; all state updates on its rising edge
- rst_n_in  input  1  synchronous, active-low reset
- flush_in  input  1  drop the held entry and any entry offered this cycle
- in_valid_in  input  1  upstream offers an instruction
- in_ready_o  output  1  stage can accept this cycle
- instr_in  input  32  instruction word
- pc_in  input  XLEN  instruction PC
- rs1_data_in  input  XLEN  register file read port 1
- rs2_data_in  input  XLEN  register file read port 2
- out_valid_o  output  1  registered entry valid toward the ALU
- out_ready_in  input  1  downstream consumes the entry
- op_1_o  output  XLEN  ALU operand 1
- op_2_o  output  XLEN  ALU operand 2
- opcode_o  output  4  ALU opcode
- rd_o  output  5  destination register
- wb_en_o  output  1  result is written back (0 for store, illegal, or rd==0)
- store_data_o  output  XLEN  rs2 data for stores
- illegal_o  output  1  unsupported instruction
- pc_o  output  XLEN  PC of the held entry

Behaviour:
- Reset (rst_n_in=0 at a clock edge): out_valid_o=0, all data outputs 0, pc_o=RESET_PC_OUT. Reset mid-stream discards the held entry.
- in_ready_o = !flush_in && (!out_valid_o || out_ready_in). This is combinational and allows a back-to-back throughput of one instruction per cycle.
- Load: when in_valid_in && in_ready_o, the output register captures the decoded fields; out_valid_o=1 next cycle. Latency is 1 cycle.
- Hold: when out_valid_o && !out_ready_in, all outputs stay stable.
- Drain: when out_ready_in && no load, out_valid_o=0 next cycle. Data outputs hold their last values.
- Flush: flush_in=1 sets out_valid_o=0 next cycle. It overrides load and hold. The input offered that cycle is not accepted.
- ALU opcode encoding: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- Decode by instr[6:0]:
  - OP 0110011: opcode={instr[30],funct3}. Legal only when funct7 is 0000000, or when funct7=0100000 with funct3 000 or 101. op_1=rs1, op_2=rs2.
  - OP-IMM 0010011: op_1=rs1, op_2=sign-extended I-immediate. opcode bit3=instr[30] only for funct3=101, else 0 (ADDI never becomes SUB). For funct3 001/101, op_2={27'b0,instr[24:20]}. Legal shift funct7 values are 0000000 (SLLI, SRLI) and 0100000 (SRAI).
  - LUI 0110111: op_1=0, op_2={instr[31:12],12'b0}, ADD.
  - AUIPC 0010111: op_1=pc, op_2=U-immediate, ADD.
  - LOAD 0000011: rs1 + I-immediate, ADD.
  - STORE 0100011: rs1 + S-immediate, ADD, wb_en=0, store_data=rs2.
  - JAL 1101111 and JALR 1100111: op_1=pc, op_2=4, ADD (link value). Target computation is outside this block.
- Shift ops from OP (opcode 0001/0101/1101): op_2 = rs2 masked to bits [4:0], upper bits zero.
- rd_o=instr[11:7]. wb_en_o=0 when rd==0.
- Illegal instruction (any other major opcode or bad funct7): illegal_o=1, opcode=0000, op_1=op_2=0, wb_en=0. The entry is still issued with out_valid_o=1.
- Arithmetic: all immediates are sign-extended from bit 31 to XLEN. No carries are generated in this block.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode localparams (ALU_ADD .. ALU_SRA);
  - RV32I major-opcode constants;
  - XLEN default.
- The ALU block imports the same opcode constants.
- One sub-module, alu_imm_gen: combinational immediate generator (I/S/U/shamt) selected by a format code.

Test Plan:
- After reset: out_valid_o=0, in_ready_o=1.
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, opcode=0000, op_1=5, op_2=7, rd=3, wb_en=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> opcode=1101, op_2=4. ADDI with imm=0x400 -> opcode=0000, op_2=0x00000400.
- Backpressure:
  - Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs stable.
  - Release -> the next instruction loads in the same cycle the held entry drains; no gap and no duplicate.
- Flush with a held entry and in_valid=1 -> next cycle out_valid=0 and the offered instruction is not accepted (in_ready=0 that cycle).
- Edge cases:
  - instr=0xFFFFFFFF -> illegal_o=1, opcode=0000, wb_en=0.
  - SW (0x00112223) -> wb_en=0, store_data=rs2, op_2=4.
  - rst_n low mid-hold -> out_valid=0 next edge.
